spram_arbiter: RTL and testbench

Two-port round-robin front end for the synchronous single-port RAM. It lets two requesters share one RAM instance: port A is the CPU data side, port B is the loader/DMA side. The block grants at most one access per cycle, drives the RAM's addr/din/we/re, and returns read data to the issuing port with fixed one-cycle latency. Each port's read data is held stable until that port's next read completes.

---
 rtl/spram_arbiter.sv | 117 +++++++++++
 tb/tb_spram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// Two-port round-robin front end for a synchronous single-port RAM.
// Grants one access per cycle and returns read data to the issuing port one cycle later.
module spram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic                  req_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  ack_a,
   output logic                  ack_b,
   output logic                  rvalid_a,
   output logic                  rvalid_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   // last_q: 0 = A granted last, 1 = B granted last
   logic                  last_q,   last_d;
   logic                  pend_a_q, pend_a_d;
   logic                  pend_b_q, pend_b_d;
   logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d;
   logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;
   logic                  grant_a;
   logic                  grant_b;

   // Round-robin grant; a contest goes to the port that did not win last
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         if (req_a && req_b) begin
            grant_a = last_q;
            grant_b = ~last_q;
         end else if (req_a) begin
            grant_a = 1'b1;
         end else if (req_b) begin
            grant_b = 1'b1;
         end
      end
   end

   // RAM drive; idle cycles park the address/data on port A
   always_comb begin
      ack_a    = grant_a;
      ack_b    = grant_b;
      mem_addr = addr_a;
      mem_din  = wdata_a;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      if (grant_a) begin
         mem_we = we_a;
         mem_re = ~we_a;
      end else if (grant_b) begin
         mem_addr = addr_b;
         mem_din  = wdata_b;
         mem_we   = we_b;
         mem_re   = ~we_b;
      end
   end

   // Read return: live RAM data in the rvalid cycle, captured copy afterwards
   always_comb begin
      rvalid_a = pend_a_q;
      rvalid_b = pend_b_q;
      rdata_a  = pend_a_q ? mem_dout : hold_a_q;
      rdata_b  = pend_b_q ? mem_dout : hold_b_q;
   end

   always_comb begin
      last_d   = last_q;
      pend_a_d = grant_a & ~we_a;
      pend_b_d = grant_b & ~we_b;
      hold_a_d = hold_a_q;
      hold_b_d = hold_b_q;
      if (grant_a) begin
         last_d = 1'b0;
      end else if (grant_b) begin
         last_d = 1'b1;
      end
      if (pend_a_q) begin
         hold_a_d = mem_dout;
      end
      if (pend_b_q) begin
         hold_b_d = mem_dout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q   <= 1'b1;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         hold_a_q <= '0;
         hold_b_q <= '0;
      end else begin
         last_q   <= last_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         hold_a_q <= hold_a_d;
         hold_b_q <= hold_b_d;
      end
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference memory and grant model.
module tb_spram_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, we_a, req_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          ack_a, ack_b, rvalid_a, rvalid_b;
   logic [DW-1:0] rdata_a, rdata_b;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we, mem_re;
   logic [DW-1:0] mem_dout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b),
      .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
      .mem_dout(mem_dout)
   );

   // Synchronous single-port RAM the arbiter drives; dout changes only on reads
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] ram_dout;
   assign mem_dout = ram_dout;
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      ram_dout = '0;
      forever begin
         @(posedge clk);
         if (mem_we) ram[mem_addr] <= mem_din;
         if (mem_re) ram_dout <= ram[mem_addr];
      end
   end

   // Reference model: memory contents as seen by requesters, last winner, per-port read return
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit            m_last;
   bit            m_rv_a, m_rv_b;
   logic [DW-1:0] m_rd_a, m_rd_b;

   task automatic model_reset();
      m_last = 1'b1;
      m_rv_a = 1'b0; m_rv_b = 1'b0;
      m_rd_a = '0;   m_rd_b = '0;
   endtask

   // One clock cycle: drive requests (called at negedge), check against the model, advance
   task automatic run_cycle(input bit ra, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                            input bit rb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                            output bit ga, output bit gb);
      bit            ea, eb;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
      #1;
      ea     = ra && (!rb || m_last);
      eb     = rb && (!ra || !m_last);
      e_addr = eb ? ab : aa;
      e_din  = eb ? db : da;
      total++; if (ack_a !== ea) begin bad++; $display("FAIL ack_a got=%b exp=%b t=%0t", ack_a, ea, $time); end
      total++; if (ack_b !== eb) begin bad++; $display("FAIL ack_b got=%b exp=%b t=%0t", ack_b, eb, $time); end
      total++; if (mem_we !== ((ea && wa) || (eb && wb)))
         begin bad++; $display("FAIL mem_we got=%b exp=%b t=%0t", mem_we, (ea && wa) || (eb && wb), $time); end
      total++; if (mem_re !== ((ea && !wa) || (eb && !wb)))
         begin bad++; $display("FAIL mem_re got=%b exp=%b t=%0t", mem_re, (ea && !wa) || (eb && !wb), $time); end
      total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL mem_addr got=%h exp=%h t=%0t", mem_addr, e_addr, $time); end
      total++; if (mem_din !== e_din) begin bad++; $display("FAIL mem_din got=%h exp=%h t=%0t", mem_din, e_din, $time); end
      total++; if (rvalid_a !== m_rv_a) begin bad++; $display("FAIL rvalid_a got=%b exp=%b t=%0t", rvalid_a, m_rv_a, $time); end
      total++; if (rvalid_b !== m_rv_b) begin bad++; $display("FAIL rvalid_b got=%b exp=%b t=%0t", rvalid_b, m_rv_b, $time); end
      total++; if (rdata_a !== m_rd_a) begin bad++; $display("FAIL rdata_a got=%h exp=%h t=%0t", rdata_a, m_rd_a, $time); end
      total++; if (rdata_b !== m_rd_b) begin bad++; $display("FAIL rdata_b got=%h exp=%h t=%0t", rdata_b, m_rd_b, $time); end
      m_rv_a = 1'b0;
      m_rv_b = 1'b0;
      if (ea) begin
         m_last = 1'b0;
         if (wa) ref_mem[aa] = da;
         else begin m_rv_a = 1'b1; m_rd_a = ref_mem[aa]; end
      end
      if (eb) begin
         m_last = 1'b1;
         if (wb) ref_mem[ab] = db;
         else begin m_rv_b = 1'b1; m_rd_b = ref_mem[ab]; end
      end
      ga = ack_a;
      gb = ack_b;
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      bit ga, gb;
      run_cycle(0, 0, '0, '0, 0, 0, '0, '0, ga, gb);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_a = 1'b1; we_a = 1'b0; addr_a = '0; wdata_a = '0;
      req_b = 1'b1; we_b = 1'b0; addr_b = '0; wdata_b = '0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", ack_a, ack_b); end
      total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("FAIL reset_mem got=%b%b exp=00", mem_we, mem_re); end
      total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid_a, rvalid_b); end
      total++; if (rdata_a !== '0 || rdata_b !== '0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata_a, rdata_b); end
      rst = 1'b0;
      req_a = 1'b0; req_b = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_write_read();
      bit ga, gb;
      run_cycle(1, 1, AW'(5), DW'(16'h1234), 0, 0, '0, '0, ga, gb);
      total++; if (ga !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", ga); end
      run_cycle(1, 0, AW'(5), '0, 0, 0, '0, '0, ga, gb);
      #1;
      total++; if (rvalid_a !== 1'b1 || rdata_a !== 16'h1234)
         begin bad++; $display("FAIL rd_after_wr got=%b/%h exp=1/1234", rvalid_a, rdata_a); end
      idle_cycle();
   endtask

   task automatic test_round_robin();
      bit            ga, gb;
      logic [AW-1:0] na, nb;
      na = AW'(32);
      nb = AW'(5);
      // B alone first so that A wins the first contested cycle
      run_cycle(0, 0, '0, '0, 1, 0, AW'(5), '0, ga, gb);
      for (int i = 0; i < 6; i++) begin
         run_cycle(1, 1, na, DW'(16'hA000 + i), 1, 0, nb, '0, ga, gb);
         total++; if (ga !== (i % 2 == 0) || gb !== (i % 2 == 1))
            begin bad++; $display("FAIL rr_order cycle=%0d got=%b%b exp=%b%b", i, ga, gb, i % 2 == 0, i % 2 == 1); end
         if (ga) na = na + AW'(1);
         if (gb) nb = AW'(32 + i);
      end
      idle_cycle();
   endtask

   task automatic test_read_then_write();
      bit ga, gb;
      run_cycle(1, 1, AW'(16), DW'(16'hBEEF), 0, 0, '0, '0, ga, gb);
      run_cycle(1, 0, AW'(16), '0, 0, 0, '0, '0, ga, gb);
      #1;
      total++; if (rvalid_a !== 1'b1 || rdata_a !== 16'hBEEF)
         begin bad++; $display("FAIL rd_wr_rvalid got=%b/%h exp=1/beef", rvalid_a, rdata_a); end
      run_cycle(0, 0, '0, '0, 1, 1, AW'(16), '0, ga, gb);
      idle_cycle();
      #1;
      total++; if (rdata_a !== 16'hBEEF) begin bad++; $display("FAIL rd_wr_hold got=%h exp=beef", rdata_a); end
   endtask

   task automatic test_hold();
      bit ga, gb;
      int cnt_a, cnt_b;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rvalid_a === 1'b1) cnt_a++;
         if (rvalid_b === 1'b1) cnt_b++;
         if (i == 0) run_cycle(1, 0, AW'(5), '0, 0, 0, '0, '0, ga, gb);
         else if (i == 1) run_cycle(0, 0, '0, '0, 1, 0, AW'(16), '0, ga, gb);
         else idle_cycle();
      end
      #1;
      total++; if (cnt_a != 1 || cnt_b != 1) begin bad++; $display("FAIL hold_pulses got=%0d/%0d exp=1/1", cnt_a, cnt_b); end
      total++; if (rdata_a !== 16'h1234) begin bad++; $display("FAIL hold_rdata_a got=%h exp=1234", rdata_a); end
      total++; if (rdata_b !== 16'h0000) begin bad++; $display("FAIL hold_rdata_b got=%h exp=0000", rdata_b); end
   endtask

   task automatic test_reset_mid();
      bit ga, gb;
      run_cycle(1, 0, AW'(5), '0, 0, 0, '0, '0, ga, gb);
      rst   = 1'b1;
      req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b0;
      #1;
      total++; if (rvalid_a !== 1'b0 || rdata_a !== '0)
         begin bad++; $display("FAIL midrst_cancel got=%b/%h exp=0/0000", rvalid_a, rdata_a); end
      total++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b%b exp=00", ack_a, ack_b); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_cycle(1, 0, AW'(16), '0, 1, 0, AW'(5), '0, ga, gb);
      total++; if (ga !== 1'b1 || gb !== 1'b0) begin bad++; $display("FAIL midrst_first got=%b%b exp=10", ga, gb); end
      run_cycle(0, 0, '0, '0, 1, 0, AW'(5), '0, ga, gb);
      total++; if (gb !== 1'b1) begin bad++; $display("FAIL midrst_second got=%b exp=1", gb); end
      idle_cycle();
   endtask

   task automatic test_random();
      bit            act_a, act_b, w_a, w_b, ga, gb;
      logic [AW-1:0] ad_a, ad_b;
      logic [DW-1:0] d_a, d_b;
      int            wait_a, wait_b;
      act_a = 0; act_b = 0; wait_a = 0; wait_b = 0;
      w_a = 0; w_b = 0; ad_a = '0; ad_b = '0; d_a = '0; d_b = '0;
      for (int i = 0; i < 10000; i++) begin
         if (!act_a && $urandom_range(0, 3) != 0) begin
            act_a = 1; w_a = 1'($urandom_range(0, 1));
            ad_a = AW'($urandom_range(0, 31)); d_a = DW'($urandom);
         end
         if (!act_b && $urandom_range(0, 3) != 0) begin
            act_b = 1; w_b = 1'($urandom_range(0, 1));
            ad_b = AW'($urandom_range(0, 31)); d_b = DW'($urandom);
         end
         run_cycle(act_a, w_a, ad_a, d_a, act_b, w_b, ad_b, d_b, ga, gb);
         total++; if (ga && gb) begin bad++; $display("FAIL rand_two_grants cycle=%0d got=11 exp=one", i); end
         if (act_a) begin
            if (ga) begin act_a = 0; wait_a = 0; end else wait_a++;
         end
         if (act_b) begin
            if (gb) begin act_b = 0; wait_b = 0; end else wait_b++;
         end
         total++; if (wait_a > 1 || wait_b > 1)
            begin bad++; $display("FAIL rand_wait cycle=%0d got=%0d/%0d exp<=1", i, wait_a, wait_b); end
      end
      idle_cycle();
      idle_cycle();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_round_robin();
      test_read_then_write();
      test_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
